aclk_keypad_scanner: RTL and testbench

Scans a 4x3 matrix keypad, debounces presses and drives the alarm-clock key interface. Outputs are a 4-bit digit code (0-9, NOKEY=10 when idle) plus level alarm_button/time_button signals. Sits between the keypad pins and the alarm-clock controller. Each output is held steady for as long as the key is physically held.

---
 rtl/aclk_pkg.sv | 33 +++
 rtl/aclk_sync2.sv | 24 ++
 rtl/aclk_keypad_scanner.sv | 160 ++++++++++++++++
 tb/tb_aclk_keypad_scanner.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aclk_pkg.sv
// Shared constants, key map and scanner state encoding for the
// alarm-clock keypad scanner (aclk_keypad_scanner, aclk_sync2).
package aclk_pkg;

    localparam int KEY_W = 4;

    localparam logic [KEY_W-1:0] NOKEY    = 4'd10;
    localparam logic [KEY_W-1:0] KEY_STAR = 4'd11;
    localparam logic [KEY_W-1:0] KEY_HASH = 4'd12;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    // Entry index is row*3 + col; r0 = "1 2 3" ... r3 = "* 0 #".
    localparam logic [11:0][KEY_W-1:0] KEY_MAP = {
        KEY_HASH, 4'd0, KEY_STAR,
        4'd9, 4'd8, 4'd7,
        4'd6, 4'd5, 4'd4,
        4'd3, 4'd2, 4'd1
    };

    function automatic logic [KEY_W-1:0] key_code(
        input logic [1:0] r,
        input logic [1:0] c
    );
        return KEY_MAP[4'(r) * 4'd3 + 4'(c)];
    endfunction

endpackage

// File: rtl/aclk_sync2.sv
// Two-flop synchronizer for asynchronous active-low sense lines.
// Ports: clk, rst (async high), d (raw), q (synchronized); resets to all-ones.
module aclk_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/aclk_keypad_scanner.sv
// 4x3 keypad scanner with debounce driving the alarm-clock key interface.
// Ports: clk, rst (async high), row_n[3:0] (one-hot low row drive),
//   col_n[2:0] (raw column sense, low = pressed), key[3:0] (0-9, 10 idle),
//   alarm_button ('*'), time_button ('#'),
//   key_strobe (only when ACLK_KEYPAD_STROBE_EN is defined: 1-clk accept pulse).
module aclk_keypad_scanner
    import aclk_pkg::*;
#(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [3:0]       row_n,
    input  logic [2:0]       col_n,
    output logic [KEY_W-1:0] key,
    output logic             alarm_button,
    output logic             time_button
`ifdef ACLK_KEYPAD_STROBE_EN
    ,
    output logic             key_strobe
`endif
);

    localparam logic [15:0] TMR_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DB_N     = 4'(DEBOUNCE_SCANS);

    logic [2:0]  col_s;
    logic [15:0] tmr;
    logic        sample;
    scan_state_t state, state_nx;
    logic [1:0]  row_q, row_nx;
    logic [1:0]  col_q, col_nx;
    logic [3:0]  dcnt, dcnt_nx;
    logic        any_low;
    logic [1:0]  low_idx;
    logic        lat_low;
    logic [KEY_W-1:0] code;

    aclk_sync2 #(.W(3)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (col_n),
        .q   (col_s)
    );

    assign sample  = (tmr == TMR_LAST);
    assign any_low = ~&col_s;
    assign row_n   = ~(4'b0001 << row_q);

    // Lowest-index low column wins within a row.
    always_comb begin
        if (!col_s[0])      low_idx = 2'd0;
        else if (!col_s[1]) low_idx = 2'd1;
        else                low_idx = 2'd2;
    end

    always_comb begin
        case (col_q)
            2'd0:    lat_low = ~col_s[0];
            2'd1:    lat_low = ~col_s[1];
            default: lat_low = ~col_s[2];
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SCAN;
            tmr   <= '0;
            row_q <= '0;
            col_q <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_nx;
            tmr   <= sample ? 16'd0 : tmr + 16'd1;
            row_q <= row_nx;
            col_q <= col_nx;
            dcnt  <= dcnt_nx;
        end
    end

    // Next state; rows only advance when no key is being tracked.
    always_comb begin
        state_nx = state;
        row_nx   = row_q;
        col_nx   = col_q;
        dcnt_nx  = dcnt;
        if (sample) begin
            unique case (state)
                SCAN: begin
                    if (any_low) begin
                        col_nx   = low_idx;
                        dcnt_nx  = 4'd1;
                        state_nx = (DB_N == 4'd1) ? PRESSED : DEBOUNCE;
                    end else begin
                        row_nx = row_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (lat_low) begin
                        dcnt_nx = dcnt + 4'd1;
                        if (dcnt + 4'd1 == DB_N) state_nx = PRESSED;
                    end else begin
                        state_nx = SCAN;
                        row_nx   = row_q + 2'd1;
                        dcnt_nx  = '0;
                    end
                end
                PRESSED: begin
                    if (!lat_low) begin
                        if (DB_N == 4'd1) begin
                            state_nx = SCAN;
                            row_nx   = row_q + 2'd1;
                            dcnt_nx  = '0;
                        end else begin
                            state_nx = RELEASE;
                            dcnt_nx  = 4'd1;
                        end
                    end
                end
                RELEASE: begin
                    if (lat_low) begin
                        state_nx = PRESSED;
                    end else if (dcnt + 4'd1 == DB_N) begin
                        state_nx = SCAN;
                        row_nx   = row_q + 2'd1;
                        dcnt_nx  = '0;
                    end else begin
                        dcnt_nx = dcnt + 4'd1;
                    end
                end
            endcase
        end
    end

    // Outputs follow the accepted key while PRESSED or releasing.
    assign code = key_code(row_q, col_q);

    always_comb begin
        key          = NOKEY;
        alarm_button = 1'b0;
        time_button  = 1'b0;
        if (state == PRESSED || state == RELEASE) begin
            if (code == KEY_STAR)      alarm_button = 1'b1;
            else if (code == KEY_HASH) time_button  = 1'b1;
            else                       key          = code;
        end
    end

`ifdef ACLK_KEYPAD_STROBE_EN
    // Fresh acceptance only; RELEASE->PRESSED bounce does not pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) key_strobe <= 1'b0;
        else key_strobe <= (state_nx == PRESSED) &&
                           (state == SCAN || state == DEBOUNCE);
    end
`endif

endmodule

// File: tb/tb_aclk_keypad_scanner.sv
// Directed self-checking bench for aclk_keypad_scanner
// (SCAN_DIV=4, DEBOUNCE_SCANS=3) with a behavioural keypad model.
module tb_aclk_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_n;
    logic [2:0] col_n;
    logic [3:0] key;
    logic       alarm_button;
    logic       time_button;
`ifdef ACLK_KEYPAD_STROBE_EN
    logic       key_strobe;
    int         strobe_cnt = 0;
    int         strobe_run = 0;
    int         strobe_wide = 0;
`endif

    int         compared = 0;
    int         mismatched = 0;
    int         both_cnt = 0;
    logic [11:0] held = '0;

    always #5 clk = ~clk;

    aclk_keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .row_n        (row_n),
        .col_n        (col_n),
        .key          (key),
        .alarm_button (alarm_button),
`ifdef ACLK_KEYPAD_STROBE_EN
        .time_button  (time_button),
        .key_strobe   (key_strobe)
`else
        .time_button  (time_button)
`endif
    );

    // Keypad: a held key pulls its column low while its row is driven.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (held[r*3+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    always @(negedge clk) begin
        if (alarm_button && time_button) both_cnt++;
`ifdef ACLK_KEYPAD_STROBE_EN
        if (key_strobe) begin
            strobe_run++;
            if (strobe_run == 1) strobe_cnt++;
            if (strobe_run > 1) strobe_wide++;
        end else begin
            strobe_run = 0;
        end
`endif
    end

    // which: 0 key, 1 alarm_button, 2 time_button. n = negedges taken, -1 on timeout.
    task automatic wait_sig(input int which, input logic [3:0] v,
                            input int budget, output int n);
        n = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which == 0 && key === v) ||
                (which == 1 && alarm_button === v[0]) ||
                (which == 2 && time_button === v[0])) begin
                n = i + 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        held = '0;
        repeat (3) @(negedge clk);
        compared++;
        if (key !== 4'd10) begin
            mismatched++;
            $display("FAIL reset_key: got %0d expected 10", key);
        end
        compared++;
        if (row_n !== 4'b1110) begin
            mismatched++;
            $display("FAIL reset_row: got %b expected 1110", row_n);
        end
        compared++;
        if ({alarm_button, time_button} !== 2'b00) begin
            mismatched++;
            $display("FAIL reset_buttons: got %b expected 00",
                     {alarm_button, time_button});
        end
    endtask

    task automatic test_idle;
        logic [3:0] exp_row;
        int bad_out;
        bad_out = 0;
        rst = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (n > 0) @(negedge clk);
            exp_row = ~(4'b0001 << ((n / 4) % 4));
            compared++;
            if (row_n !== exp_row) begin
                mismatched++;
                $display("FAIL idle_row[%0d]: got %b expected %b",
                         n, row_n, exp_row);
            end
            if (key !== 4'd10 || alarm_button || time_button) bad_out++;
        end
        compared++;
        if (bad_out != 0) begin
            mismatched++;
            $display("FAIL idle_outputs: %0d non-idle cycles expected 0", bad_out);
        end
    endtask

    task automatic test_hold5;
        int n;
        int moved;
        held[4] = 1'b1;
        wait_sig(0, 4'd5, 30, n);
        compared++;
        if (n < 0) begin
            mismatched++;
            $display("FAIL press5_latency: key %0d expected 5 within 30", key);
        end
        moved = 0;
        repeat (8) begin
            @(negedge clk);
            if (row_n !== 4'b1101 || key !== 4'd5) moved++;
        end
        compared++;
        if (moved != 0) begin
            mismatched++;
            $display("FAIL press5_hold: %0d cycles row_n/key changed, expected 0",
                     moved);
        end
        held = '0;
        repeat (8) @(negedge clk);
        compared++;
        if (key !== 4'd5) begin
            mismatched++;
            $display("FAIL release5_early: got %0d expected 5", key);
        end
        wait_sig(0, 4'd10, 20, n);
        compared++;
        if (n < 0) begin
            mismatched++;
            $display("FAIL release5: key %0d expected 10 within 20", key);
        end
    endtask

    task automatic test_bounce;
        int n;
        int bad;
        bad = 0;
        for (int i = 0; i < 20 && row_n === 4'b1011; i++) @(negedge clk);
        for (int i = 0; i < 20 && row_n !== 4'b1011; i++) @(negedge clk);
        held[7] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (key !== 4'd10) bad++;
        end
        compared++;
        if (row_n !== 4'b1011) begin
            mismatched++;
            $display("FAIL bounce_frozen: got %b expected 1011", row_n);
        end
        held[7] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (key !== 4'd10) bad++;
        end
        compared++;
        if (row_n !== 4'b0111) begin
            mismatched++;
            $display("FAIL bounce_advance: got %b expected 0111", row_n);
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL bounce_no_output: %0d cycles key!=10 expected 0", bad);
        end
        held[7] = 1'b1;
        wait_sig(0, 4'd8, 40, n);
        compared++;
        if (n != 24) begin
            mismatched++;
            $display("FAIL bounce_accept8: cycles %0d expected 24", n);
        end
        held = '0;
        wait_sig(0, 4'd10, 20, n);
        compared++;
        if (n < 0) begin
            mismatched++;
            $display("FAIL release8: key %0d expected 10", key);
        end
    endtask

    task automatic test_star_hash;
        int n;
        int both0;
        both0 = both_cnt;
        held[9] = 1'b1;
        wait_sig(1, 4'd1, 40, n);
        compared++;
        if (n < 0 || key !== 4'd10 || time_button !== 1'b0) begin
            mismatched++;
            $display("FAIL star: alarm %b key %0d time %b expected 1 10 0",
                     alarm_button, key, time_button);
        end
        held = '0;
        wait_sig(1, 4'd0, 20, n);
        compared++;
        if (n < 0) begin
            mismatched++;
            $display("FAIL star_release: alarm %b expected 0", alarm_button);
        end
        held[11] = 1'b1;
        wait_sig(2, 4'd1, 40, n);
        compared++;
        if (n < 0 || key !== 4'd10 || alarm_button !== 1'b0) begin
            mismatched++;
            $display("FAIL hash: time %b key %0d alarm %b expected 1 10 0",
                     time_button, key, alarm_button);
        end
        held = '0;
        wait_sig(2, 4'd0, 20, n);
        compared++;
        if (n < 0) begin
            mismatched++;
            $display("FAIL hash_release: time %b expected 0", time_button);
        end
        compared++;
        if (both_cnt != both0) begin
            mismatched++;
            $display("FAIL buttons_exclusive: %0d both-high cycles expected 0",
                     both_cnt - both0);
        end
    endtask

    task automatic test_two_keys;
        int n;
        held[0] = 1'b1;
        held[2] = 1'b1;
        wait_sig(0, 4'd1, 40, n);
        compared++;
        if (n < 0) begin
            mismatched++;
            $display("FAIL two_keys_low: key %0d expected 1", key);
        end
        held[0] = 1'b0;
        wait_sig(0, 4'd10, 20, n);
        compared++;
        if (n < 0) begin
            mismatched++;
            $display("FAIL two_keys_gap: key %0d expected 10", key);
        end
        wait_sig(0, 4'd3, 40, n);
        compared++;
        if (n < 0) begin
            mismatched++;
            $display("FAIL two_keys_second: key %0d expected 3", key);
        end
        held = '0;
        wait_sig(0, 4'd10, 20, n);
    endtask

    task automatic test_reset_mid;
        int n;
        held[8] = 1'b1;
        wait_sig(0, 4'd9, 40, n);
        compared++;
        if (n < 0) begin
            mismatched++;
            $display("FAIL hold9: key %0d expected 9", key);
        end
        #2 rst = 1'b1;
        #1;
        compared++;
        if (key !== 4'd10 || row_n !== 4'b1110) begin
            mismatched++;
            $display("FAIL async_reset: key %0d row %b expected 10 1110",
                     key, row_n);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_sig(0, 4'd9, 40, n);
        compared++;
        if (n != 20) begin
            mismatched++;
            $display("FAIL redetect9: cycles %0d expected 20", n);
        end
        held = '0;
        wait_sig(0, 4'd10, 20, n);
    endtask

`ifdef ACLK_KEYPAD_STROBE_EN
    task automatic test_strobe;
        compared++;
        if (strobe_cnt != 8) begin
            mismatched++;
            $display("FAIL strobe_count: got %0d expected 8", strobe_cnt);
        end
        compared++;
        if (strobe_wide != 0) begin
            mismatched++;
            $display("FAIL strobe_width: %0d extra cycles expected 0", strobe_wide);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_idle;
        test_hold5;
        test_bounce;
        test_star_hash;
        test_two_keys;
        test_reset_mid;
`ifdef ACLK_KEYPAD_STROBE_EN
        test_strobe;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
